excess3_to_bcd_seq: RTL
=======================

Name: excess3_to_bcd_seq

Overview:
- Multi-digit Excess-3 to BCD decoder; the inverse of the team's BCD-to-Excess-3 converter.
- Accepts a packed word of NDIG Excess-3 digits over a valid/ready handshake.
- Converts serially, one digit per clock, least-significant digit first.
- Presents the packed BCD result plus a per-digit invalid-code mask on an output valid/ready handshake.
- Sits between the Excess-3 display/arith datapath and BCD consumers.

Parameters:
- NDIG, 4, number of 4-bit digits per word (1..8).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  e3_in holds a word to convert.
- in_ready  output  1  block can accept a word (high only in IDLE).
- e3_in  input  4*NDIG  packed Excess-3 digits; digit i at bits [4i+3:4i].
- out_valid  output  1  bcd_out/err_mask hold a finished result.
- out_ready  input  1  consumer takes the result.
- bcd_out  output  4*NDIG  packed BCD result; digit i at bits [4i+3:4i].
- err_mask  output  NDIG  bit i set when input digit i was not a legal Excess-3 code.

Behaviour:
- Reset values:
  - On rst high at a clock edge: state=IDLE, digit counter=0, bcd_out=0, err_mask=0, out_valid=0.
  - in_ready=1 from the first cycle after reset.
  - rst overrides every other input, including in the middle of CONV or DONE.
  - A word in progress is discarded and never produces out_valid.
- States: IDLE, CONV, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE); out_valid is registered, not combinational from inputs.
- IDLE:
  - in_valid & in_ready at an edge: capture e3_in into the internal shift register, clear bcd_out and err_mask, counter=0, go CONV.
  - in_valid low: stay in IDLE.
- CONV, each edge processes digit[counter]:
  - Legal code 4'b0011..4'b1100: BCD digit = code - 4'b0011, 4-bit arithmetic. The result is always 0..9, so no wrap.
  - Illegal code (0000-0010, 1101-1111): BCD digit = 4'hF and err_mask[counter] = 1.
  - The result is written into bcd_out digit position counter.
  - Counter increments.
  - When counter == NDIG-1 on this edge, go DONE and leave the counter at its final value.
  - in_valid is ignored in CONV.
- DONE:
  - out_valid=1; bcd_out and err_mask are held stable until the handshake completes.
  - out_valid & out_ready at an edge: go IDLE. bcd_out and err_mask keep their values until the next accept.
  - out_ready low: stay in DONE indefinitely; no new input is accepted.
- Latency and throughput:
  - Accept at edge k gives out_valid high after edge k+NDIG.
  - Minimum word period is NDIG+2 cycles: accept, NDIG conversions, DONE handshake, with IDLE re-entry overlapping the next accept cycle.
  - There is no bypass path from DONE directly to CONV.
- Boundaries:
  - out_ready asserted while out_valid is low has no effect.
  - in_valid held high continuously: a new word is accepted on the first IDLE cycle after each DONE handshake.
  - NDIG=1: CONV lasts exactly one cycle.
  - Each digit is converted independently; there is no carry between digits.

Test Plan (NDIG=4):
- Legal word: e3_in=16'h3456, in_valid pulse accepted at edge k -> out_valid high after edge k+4, bcd_out=16'h0123, err_mask=4'b0000.
- Upper bound: e3_in=16'hCCCC -> bcd_out=16'h9999, err_mask=0.
- Illegal digits: e3_in=16'h3F03 -> bcd_out=16'h0FF0, err_mask=4'b0110.
- Exhaustive digit sweep: for each code c in 0..15, e3_in={12'h333, c}.
  - Legal c: bcd_out[3:0]=c-3, bcd_out[15:4]=0, err_mask=0.
  - Illegal c: bcd_out[3:0]=F, err_mask=4'b0001.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises.
  - bcd_out, err_mask and out_valid stay stable.
  - in_ready stays 0; a second word presented with in_valid=1 is not taken.
  - When out_ready rises, the handshake completes, then the second word is accepted on the next IDLE cycle and gives its correct result.
- Reset mid-operation: accept 16'h4567, assert rst for one cycle after 2 CONV cycles.
  - Next cycle: out_valid=0, bcd_out=0, err_mask=0, in_ready=1.
  - A following word 16'h3C3C gives 16'h0909 with no leftover state.

Source files
------------

// File: rtl/excess3_to_bcd_seq.sv
// Multi-digit Excess-3 to BCD decoder: one digit per clock, LSD first,
// with valid/ready handshakes on both sides and a per-digit illegal-code mask.
module excess3_to_bcd_seq #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] e3_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] bcd_out,
  output logic [NDIG-1:0]   err_mask
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [4*NDIG-1:0] r_sr;
  logic [4*NDIG-1:0] r_bcd;
  logic [NDIG-1:0]   r_err;
  logic [3:0]        w_digit;
  logic              w_illegal;
  logic              w_last;

  function automatic logic e3_illegal(input logic [3:0] code);
    return (code < 4'd3) || (code > 4'd12);
  endfunction

  function automatic logic [3:0] e3_decode(input logic [3:0] code);
    return e3_illegal(code) ? 4'hF : (code - 4'd3);
  endfunction

  // The digit being converted always sits in the low nibble of the shifter.
  always_comb begin
    w_digit   = e3_decode(r_sr[3:0]);
    w_illegal = e3_illegal(r_sr[3:0]);
    w_last    = (r_cnt == LAST);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_CONV;
      S_CONV:  if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_bcd <= '0;
      r_err <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sr  <= e3_in;
            r_bcd <= '0;
            r_err <= '0;
            r_cnt <= '0;
          end
        end
        S_CONV: begin
          r_sr <= r_sr >> 4;
          for (int i = 0; i < NDIG; i++) begin
            if (r_cnt == CW'(i)) begin
              r_bcd[4*i +: 4] <= w_digit;
              r_err[i]        <= w_illegal;
            end
          end
          // Counter parks on the last digit index once the word is done.
          if (!w_last) r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign bcd_out   = r_bcd;
  assign err_mask  = r_err;

endmodule
